// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler and the digest serializer.
//   sched_state_t     : scheduler FSM encoding
//   SHA1_DIGEST_BYTES : payload size of one SHA-1 digest
//   rr_next()         : round-robin pointer advance modulo the requester count
// Build option: UART_TX_SCHED_CHKSUM_EN adds the CHK/WAITC states.
package uart_sched_pkg;

    localparam int SHA1_DIGEST_BYTES = 20;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SEND  = 3'd2,
        WAIT  = 3'd3,
`ifdef UART_TX_SCHED_CHKSUM_EN
        CHK   = 3'd4,
        WAITC = 3'd5,
`endif
        END   = 3'd6
    } sched_state_t;

    function automatic logic [1:0] rr_next(input logic [1:0] idx, input int n);
        if (int'(idx) >= n - 1) return 2'd0;
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte-stream bus between the requesters, the scheduler and uart_byte_tx.
//   req_vld/req_data/req_last : requester i presents a byte (data in [8i+7:8i])
//   req_rdy                   : one-cycle consume pulse back to requester i
//   tx_send_en/tx_data        : start pulse and byte to the transmitter
//   tx_done                   : transmitter finished the byte
// modport master : the scheduler; modport slave : requesters + transmitter.
interface uart_tx_sched_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_vld;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_rdy;
    logic              tx_send_en;
    logic [7:0]        tx_data;
    logic              tx_done;

    modport master (
        input  req_vld, req_data, req_last, tx_done,
        output req_rdy, tx_send_en, tx_data
    );

    modport slave (
        output req_vld, req_data, req_last, tx_done,
        input  req_rdy, tx_send_en, tx_data
    );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
//   req     : request vector
//   ptr     : highest-priority index (must be < NREQ)
//   gnt     : one-hot winner, 0 when no request
//   gnt_idx : binary index of the winner
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_idx
);
    logic found;

    // Two passes avoid a modulo index: indices >= ptr first, then the wrap.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && i >= int'(ptr) && req[i]) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = 2'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && i < int'(ptr) && req[i]) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = 2'(i);
            end
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_byte_tx among NREQ byte streams.
// A granted requester keeps the transmitter for a whole message (until its
// last flag, or until MAX_LEN bytes force an end and set len_err).
// Ports: clk, rstn (async active-low); bus (uart_tx_sched_if.master);
//   grant (one-hot owner), busy, frame_done (pulse), len_err (sticky),
//   err_clr (clears len_err; a simultaneous overflow wins).
// Build option: UART_TX_SCHED_CHKSUM_EN appends an XOR checksum byte.
//
// state | meaning
// IDLE  | no owner; arbitrate among req_vld
// LOAD  | wait for owner's byte, consume it
// SEND  | one-cycle tx_send_en for the payload byte
// WAIT  | wait for tx_done; decide next byte or end of message
// CHK   | one-cycle tx_send_en for the checksum byte
// WAITC | wait for tx_done of the checksum byte
// END   | frame_done pulse, release grant
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int MAX_LEN = SHA1_DIGEST_BYTES,
    parameter int LEN_W   = 5
) (
    input  logic            clk,
    input  logic            rstn,
    uart_tx_sched_if.master bus,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic            frame_done,
    output logic            len_err,
    input  logic            err_clr
);
    if (MAX_LEN >= (1 << LEN_W)) begin : g_len_w_check
        $error("LEN_W too narrow for MAX_LEN");
    end

`ifdef UART_TX_SCHED_CHKSUM_EN
    localparam sched_state_t MSG_END_ST = CHK;
    logic [7:0] chk_q, chk_d;
`else
    localparam sched_state_t MSG_END_ST = END;
`endif

    sched_state_t     state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [NREQ-1:0]  grant_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             last_q, last_d;
    logic             len_err_d;

    logic [NREQ-1:0]  pick;
    logic [1:0]       pick_idx;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             sel_vld;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req_vld),
        .ptr     (ptr_q),
        .gnt     (pick),
        .gnt_idx (pick_idx)
    );

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_data = bus.req_data[8*i +: 8];
                sel_last = bus.req_last[i];
            end
        end
    end

    assign sel_vld = |(bus.req_vld & grant);
    assign busy    = (state_q != IDLE);

`ifdef UART_TX_SCHED_CHKSUM_EN
    assign bus.tx_data = (state_q == CHK || state_q == WAITC) ? chk_q : data_q;
`else
    assign bus.tx_data = data_q;
`endif

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        grant_d        = grant;
        cnt_d          = cnt_q;
        data_d         = data_q;
        last_d         = last_q;
        len_err_d      = len_err & ~err_clr;
        bus.req_rdy    = '0;
        bus.tx_send_en = 1'b0;
        frame_done     = 1'b0;
`ifdef UART_TX_SCHED_CHKSUM_EN
        chk_d          = chk_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req_vld) begin
                    grant_d = pick;
                    ptr_d   = rr_next(pick_idx, NREQ);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (sel_vld) begin
                    bus.req_rdy = grant;
                    data_d      = sel_data;
                    last_d      = sel_last;
                    if (cnt_q != LEN_W'(MAX_LEN)) cnt_d = cnt_q + 1'b1;
`ifdef UART_TX_SCHED_CHKSUM_EN
                    chk_d       = chk_q ^ sel_data;
`endif
                    state_d     = SEND;
                end
            end
            SEND: begin
                bus.tx_send_en = 1'b1;
                state_d        = WAIT;
            end
            WAIT: begin
                if (bus.tx_done) begin
                    if (last_q) begin
                        state_d = MSG_END_ST;
                    end else if (cnt_q == LEN_W'(MAX_LEN)) begin
                        len_err_d = 1'b1;
                        state_d   = MSG_END_ST;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
`ifdef UART_TX_SCHED_CHKSUM_EN
            CHK: begin
                bus.tx_send_en = 1'b1;
                state_d        = WAITC;
            end
            WAITC: begin
                if (bus.tx_done) state_d = END;
            end
`endif
            END: begin
                frame_done = 1'b1;
                grant_d    = '0;
                cnt_d      = '0;
`ifdef UART_TX_SCHED_CHKSUM_EN
                chk_d      = '0;
`endif
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            len_err <= 1'b0;
`ifdef UART_TX_SCHED_CHKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant   <= grant_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            len_err <= len_err_d;
`ifdef UART_TX_SCHED_CHKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: requester queues and a transmitter model
// driven from one step task; expected bytes are queued when a message is
// composed and popped on every tx_send_en.
module tb_uart_tx_sched;
    import uart_sched_pkg::*;

    localparam int NREQ    = 2;
    localparam int MAX_LEN = 20;
    localparam int LEN_W   = 5;
`ifdef UART_TX_SCHED_CHKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    typedef struct packed { logic [7:0] data; logic last; } req_byte_t;
    typedef struct packed { logic [1:0] id; logic [7:0] data; } exp_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            err_clr = 1'b0;
    logic [NREQ-1:0] grant;
    logic            busy, frame_done, len_err;

    uart_tx_sched_if #(.NREQ(NREQ)) bus ();

    uart_tx_sched #(.NREQ(NREQ), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .grant      (grant),
        .busy       (busy),
        .frame_done (frame_done),
        .len_err    (len_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    req_byte_t rq[NREQ][$];
    exp_t      exp_q[$];
    exp_t      e_cur;
    int        n_vec = 0, n_err = 0;
    int        frames = 0, sends = 0, txd_cnt = 0, timer = 0;
    int        rdy_cnt[NREQ];
    bit        pend[NREQ];
    bit        hold[NREQ];
    bit        clr_req = 1'b0;
    int        clr_at_txd = -1;
    bit        send_seen = 1'b0;
    bit        hold_valid = 1'b0;
    logic [7:0] last_sent = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_req(input int id, input logic [7:0] d, input bit last);
        req_byte_t b;
        b.data = d;
        b.last = last;
        rq[id].push_back(b);
    endtask

    task automatic add_exp(input int id, input logic [7:0] d);
        exp_t x;
        x.id   = 2'(id);
        x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic add_chk(input int id, input logic [7:0] c);
        if (CHK_ON) add_exp(id, c);
    endtask

    // n bytes base, base+1, ... with the last flag on the final byte
    task automatic push_msg(input int id, input int n, input logic [7:0] base);
        logic [7:0] c = '0;
        for (int i = 0; i < n; i++) begin
            add_req(id, base + 8'(i), i == n - 1);
            add_exp(id, base + 8'(i));
            c ^= base + 8'(i);
        end
        add_chk(id, c);
    endtask

    task automatic flush();
        for (int i = 0; i < NREQ; i++) begin
            rq[i].delete();
            pend[i] = 1'b0;
            hold[i] = 1'b0;
        end
        exp_q.delete();
        hold_valid = 1'b0;
    endtask

    // One clock: inputs change at negedge, outputs sampled 1 time unit later.
    task step();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
                pend[i] = 1'b0;
                if (rq[i].size() > 0) void'(rq[i].pop_front());
            end
        end
        bus.tx_done = 1'b0;
        err_clr = clr_req;
        clr_req = 1'b0;
        if (timer > 0) begin
            timer--;
            if (timer == 0) begin
                bus.tx_done = 1'b1;
                txd_cnt++;
                if (txd_cnt == clr_at_txd) err_clr = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0 && !hold[i]) begin
                bus.req_vld[i]          = 1'b1;
                bus.req_data[8*i +: 8]  = rq[i][0].data;
                bus.req_last[i]         = rq[i][0].last;
            end else begin
                bus.req_vld[i]          = 1'b0;
                bus.req_data[8*i +: 8]  = 8'h00;
                bus.req_last[i]         = 1'b0;
            end
        end
        #1;
        send_seen = bus.tx_send_en;
        if (bus.tx_done && hold_valid)
            check("tx_data_hold", 32'(bus.tx_data), 32'(last_sent));
        if (bus.tx_send_en) begin
            sends++;
            timer      = 10;
            last_sent  = bus.tx_data;
            hold_valid = 1'b1;
            check("send_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() > 0) begin
                e_cur = exp_q.pop_front();
                check("tx_data", 32'(bus.tx_data), 32'(e_cur.data));
                check("grant_owner", 32'(grant), 32'd1 << e_cur.id);
            end
        end
        if (frame_done) frames++;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_rdy[i]) begin
                rdy_cnt[i]++;
                pend[i] = 1'b1;
            end
        end
    endtask

    function automatic int cur(input int which);
        case (which)
            0:       return frames;
            1:       return sends;
            default: return txd_cnt;
        endcase
    endfunction

    task automatic wait_cnt(input int which, input int target, input int budget, input string tag);
        int n = 0;
        while (cur(which) < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(cur(which)), 32'(target));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},  32'(grant), 32'd0);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_frame"},  32'(frame_done), 32'd0);
        check({tag, "_lenerr"}, 32'(len_err), 32'd0);
        check({tag, "_send"},   32'(bus.tx_send_en), 32'd0);
        check({tag, "_txdata"}, 32'(bus.tx_data), 32'd0);
        check({tag, "_rdy"},    32'(bus.req_rdy), 32'd0);
    endtask

    task automatic reset_pulse();
        rstn = 1'b0;
        flush();
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        int f0, r0, s0, t0;
        logic [7:0] c;
        for (int i = 0; i < NREQ; i++) begin
            rdy_cnt[i] = 0;
            pend[i]    = 1'b0;
            hold[i]    = 1'b0;
        end
        bus.req_vld  = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        bus.tx_done  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;

        // single message from requester 0
        add_req(0, 8'h11, 1'b0); add_exp(0, 8'h11);
        add_req(0, 8'h22, 1'b0); add_exp(0, 8'h22);
        add_req(0, 8'h33, 1'b1); add_exp(0, 8'h33);
        add_chk(0, 8'h00);
        f0 = frames;
        r0 = rdy_cnt[0];
        wait_cnt(0, f0 + 1, 300, "single_frame");
        check("single_grant_end", 32'(grant), 32'd1);
        step();
        check("single_grant_idle", 32'(grant), 32'd0);
        check("single_busy_idle", 32'(busy), 32'd0);
        check("single_rdy_count", 32'(rdy_cnt[0] - r0), 32'd3);
        check("single_exp_drained", 32'(exp_q.size()), 32'd0);

        // contention from reset pointer 0: 0, 1, 0
        reset_pulse();
        push_msg(0, 2, 8'hA0);
        push_msg(1, 3, 8'hB0);
        push_msg(0, 1, 8'hC0);
        wait_cnt(0, frames + 3, 1500, "contention_frames");
        check("contention_exp_drained", 32'(exp_q.size()), 32'd0);

        // requester 1 stalls mid-message
        push_msg(1, 4, 8'hD0);
        r0 = rdy_cnt[1];
        wait_cnt(2, txd_cnt + 2, 300, "stall_reach");
        hold[1] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            check("stall_no_send", 32'(send_seen), 32'd0);
            check("stall_grant", 32'(grant), 32'd2);
            check("stall_busy", 32'(busy), 32'd1);
        end
        hold[1] = 1'b0;
        wait_cnt(0, frames + 1, 500, "stall_frame");
        check("stall_rdy_count", 32'(rdy_cnt[1] - r0), 32'd4);
        check("stall_exp_drained", 32'(exp_q.size()), 32'd0);

        // overflow: 25 bytes without last; 20 go out, rest start the next message
        c = '0;
        for (int i = 0; i < 25; i++) begin
            add_req(0, 8'h40 + 8'(i), 1'b0);
            add_exp(0, 8'h40 + 8'(i));
            c ^= 8'h40 + 8'(i);
            if (i == MAX_LEN - 1) begin
                add_chk(0, c);
                c = '0;
            end
        end
        add_req(0, 8'h99, 1'b1); add_exp(0, 8'h99);
        add_chk(0, c ^ 8'h99);
        s0 = sends;
        wait_cnt(0, frames + 1, 1000, "ovf_frame");
        check("ovf_len_err", 32'(len_err), 32'd1);
        check("ovf_send_count", 32'(sends - s0), 32'(MAX_LEN + int'(CHK_ON)));
        wait_cnt(0, frames + 1, 600, "ovf_next_frame");
        check("ovf_len_err_sticky", 32'(len_err), 32'd1);
        check("ovf_exp_drained", 32'(exp_q.size()), 32'd0);
        clr_req = 1'b1;
        step();
        step();
        check("err_clr", 32'(len_err), 32'd0);

        // err_clr in the very cycle of a new overflow: set wins
        clr_at_txd = txd_cnt + MAX_LEN;
        c = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            add_req(0, 8'h60 + 8'(i), 1'b0);
            add_exp(0, 8'h60 + 8'(i));
            c ^= 8'h60 + 8'(i);
        end
        add_chk(0, c);
        add_req(0, 8'h77, 1'b1); add_exp(0, 8'h77);
        add_chk(0, 8'h77);
        wait_cnt(0, frames + 1, 1000, "ovf2_frame");
        check("ovf2_set_wins", 32'(len_err), 32'd1);
        wait_cnt(0, frames + 1, 300, "ovf2_next_frame");
        clr_at_txd = -1;

        // reset in WAIT after byte 5 of a digest
        push_msg(0, SHA1_DIGEST_BYTES, 8'hE0);
        wait_cnt(1, sends + 5, 300, "rst_reach");
        repeat (3) step();
        rstn = 1'b0;
        #1;
        check_all_zero("midrst");
        flush();
        step();
        rstn = 1'b1;
        s0 = sends;
        f0 = frames;
        t0 = txd_cnt;
        repeat (15) step();
        check("rst_spurious_done_seen", 32'(txd_cnt - t0), 32'd1);
        check("rst_no_send", 32'(sends), 32'(s0));
        check("rst_no_frame", 32'(frames), 32'(f0));
        check("rst_busy", 32'(busy), 32'd0);

        // fresh request: tx_send_en in the third cycle
        push_msg(1, 2, 8'h55);
        step();
        check("lat_cycle1", 32'(send_seen), 32'd0);
        step();
        check("lat_cycle2", 32'(send_seen), 32'd0);
        step();
        check("lat_cycle3", 32'(send_seen), 32'd1);
        wait_cnt(0, frames + 1, 300, "lat_frame");
        check("final_exp_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares the single uart_byte_tx byte transmitter among NREQ byte-stream requesters, such as the SHA-1 digest streamer and a status/echo responder.
- Each granted requester owns the transmitter for one whole message, delimited by its last flag.
- The block paces the transmitter byte by byte using send_en and tx_done.
- Optionally, it appends an XOR checksum byte to each message.

Parameters:
- NREQ, 2, number of requesters (2..4)
- MAX_LEN, 20, maximum payload bytes per message (a SHA-1 digest is 20 bytes)
- LEN_W, 5, width of the byte counter; must satisfy 2^LEN_W > MAX_LEN

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req_vld  in  NREQ  requester i presents a byte
- req_data  in  8*NREQ  byte of requester i in bits [8i+7:8i]
- req_last  in  NREQ  byte of requester i is the last of its message
- req_rdy  out  NREQ  one-cycle pulse: byte of requester i consumed
- tx_send_en  out  1  one-cycle start pulse to the transmitter
- tx_data  out  8  byte to transmit; held stable from the pulse until tx_done
- tx_done  in  1  one-cycle pulse from the transmitter: byte finished
- grant  out  NREQ  one-hot owner of the current message; 0 when idle
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the final byte's tx_done
- len_err  out  1  sticky overflow flag; cleared only by reset or err_clr
- err_clr  in  1  clears len_err

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-low, on rstn.
- Reset values: all outputs are 0. State is IDLE, the round-robin pointer is 0, the byte counter is 0 and the checksum is 0.
- Reset mid-message: everything aborts immediately. Any byte already handed to the transmitter is not tracked further.
- IDLE:
  - If any req_vld is high, pick the first requester at or after the pointer (wrapping modulo NREQ).
  - Register its one-hot grant and go to LOAD.
  - The pointer becomes the winner + 1 (mod NREQ), so the winner has lowest priority next.
- LOAD:
  - If req_vld[g] is high: pulse req_rdy[g], latch req_data and req_last, increment the byte counter, XOR the byte into the checksum, go to SEND.
  - Otherwise stall in LOAD indefinitely; the grant is held.
- SEND: assert tx_send_en for exactly one cycle, then go to WAIT.
- WAIT: stay until tx_done. Then:
  - if the latched last flag is set, go to CHK (feature on) or END (feature off);
  - else if the byte counter equals MAX_LEN, set len_err and treat this byte as last;
  - else return to LOAD.
- CHK: drive the checksum on tx_data and pulse tx_send_en, go to WAITC. WAITC goes to END on tx_done.
- END: pulse frame_done, clear grant, the counter and the checksum, go to IDLE.
- Latency:
  - req_vld rising in IDLE to tx_send_en is 3 cycles (IDLE, LOAD, SEND).
  - tx_done to the next tx_send_en is 2 cycles when the requester's byte is already valid.
- Ignored inputs: tx_done is ignored outside WAIT and WAITC. Requests from other requesters are ignored while a grant is held; messages are never interleaved.
- err_clr and an overflow in the same cycle: the set wins.
- Counter: saturates at MAX_LEN and never wraps.

Optional Feature:
- Macro: UART_TX_SCHED_CHKSUM_EN.
- Defined: after the last payload byte, one extra byte is sent, equal to the XOR of all payload bytes. It is also sent on a forced end caused by len_err.
- Undefined: the CHK and WAITC states and the checksum register are absent, and WAIT goes directly to END.

Decomposition:
- Shared package uart_sched_pkg holds:
  - the state encoding: IDLE, LOAD, SEND, WAIT, CHK, WAITC, END;
  - the SHA1_DIGEST_BYTES = 20 constant, reused by the digest serializer.
- One natural sub-module, rr_arbiter: a combinational round-robin one-hot picker from the req and pointer inputs, parameterised by NREQ.

Test Plan:
- Single message: requester 0 sends 0x11, 0x22, 0x33 (last on 0x33); tx_done returns 10 cycles after each pulse.
  - Required: tx_data sequence 11, 22, 33; three req_rdy[0] pulses; one frame_done; grant 01 then 00.
  - With the feature: a fourth byte 0x00 (11^22^33 = 00).
- Contention: req_vld = 11 held with reset pointer 0.
  - Required: requester 0's whole message, then requester 1's whole message, then requester 0 again.
  - No interleaving while grant is held.
- Stall: requester 1 drops req_vld for 7 cycles mid-message.
  - Required: the block stays in LOAD, no tx_send_en, grant stays 10, and it resumes on the same requester.
- Overflow: 25 bytes with no last flag.
  - Required: exactly 20 payload bytes sent, len_err=1, frame_done pulses, next message is accepted.
  - err_clr clears len_err; err_clr asserted in the same cycle as a new overflow leaves len_err=1.
- Reset mid-message: rstn low in WAIT after byte 5 of a 20-byte SHA digest.
  - Required: all outputs 0 immediately, and a spurious tx_done after reset causes no activity.
  - A fresh request gives tx_send_en 3 cycles after req_vld.
